axilite_aes_key_bank: RTL

- AXI4-Lite slave holding AES key material for the AXIS AES datapath.
- Generalises the 4×32-bit key register block: 128, 192 or 256-bit keys, multiple key slots, a commit handshake to the cipher core, a sticky lock, and optional write-only keys.
- Software writes staging words, then sets COMMIT. The block snapshots the staging words and presents them on a valid/ready key port until the core accepts them.

---
 rtl/axilite_aes_key_bank.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axilite_aes_key_bank.sv
// AXI4-Lite key bank: staging words, CTRL/STATUS, sticky lock, and a
// valid/ready port that hands a committed key snapshot to the cipher core.
module axilite_aes_key_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int KEY_WIDTH          = 128,
    parameter int NUM_SLOTS          = 4,
    parameter int KEY_READBACK       = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [KEY_WIDTH-1:0]            key_data,
    output logic [3:0]                      key_slot,
    output logic                            key_valid,
    input  logic                            key_ready
);
    localparam int unsigned NUM_WORDS   = KEY_WIDTH / 32;
    localparam logic [3:0]  LAST_WORD   = 4'(NUM_WORDS - 1);
    localparam logic [7:0]  WORDS_FIELD = 8'(NUM_WORDS);
    localparam logic [4:0]  SLOT_LIMIT  = 5'(NUM_SLOTS);
    localparam logic [3:0]  IDX_CTRL    = 4'd8;
    localparam logic [3:0]  IDX_STATUS  = 4'd9;

    logic                 aw_ready, b_valid, ar_ready, r_valid;
    logic [1:0]           b_resp;
    logic [31:0]          r_data, rd_word;
    logic [31:0]          stage [NUM_WORDS];
    logic [KEY_WIDTH-1:0] stage_flat, key_q;
    logic [3:0]           slot, key_slot_q, commit_slot;
    logic                 lock, key_valid_q;
    logic [7:0]           commit_cnt;
    logic [3:0]           wr_idx, rd_idx;
    logic                 wr_en, rd_en, key_hs;
    logic                 wr_err, key_wr, slot_wr, lock_set, commit_req, commit_ok;
    logic                 unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign wr_idx = S_AXI_AWADDR[5:2];
    assign rd_idx = S_AXI_ARADDR[5:2];
    assign wr_en  = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en  = ar_ready && S_AXI_ARVALID;
    assign key_hs = key_valid_q && key_ready;

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = '0;
    assign key_data      = key_q;
    assign key_slot      = key_slot_q;
    assign key_valid     = key_valid_q;

    // While locked the SLOT field of a CTRL write is ignored, so COMMIT stays usable
    // and tags the key with the SLOT held before the lock.
    always_comb begin
        wr_err      = 1'b0;
        key_wr      = 1'b0;
        slot_wr     = 1'b0;
        lock_set    = 1'b0;
        commit_req  = 1'b0;
        commit_ok   = 1'b0;
        commit_slot = slot;
        if (wr_en) begin
            if (wr_idx <= LAST_WORD) begin
                wr_err = lock;
                key_wr = !lock;
            end else if (wr_idx == IDX_CTRL) begin
                commit_req = S_AXI_WSTRB[0] && S_AXI_WDATA[0];
                if (!lock && S_AXI_WSTRB[0])
                    commit_slot = S_AXI_WDATA[7:4];
                if (commit_req) begin
                    if ((key_valid_q && !key_ready) || ({1'b0, commit_slot} >= SLOT_LIMIT))
                        wr_err = 1'b1;
                    else
                        commit_ok = 1'b1;
                end else if (lock && S_AXI_WSTRB[0]) begin
                    wr_err = 1'b1;
                end
                if (!wr_err) begin
                    slot_wr  = !lock && S_AXI_WSTRB[0];
                    lock_set = S_AXI_WSTRB[3] && S_AXI_WDATA[31];
                end
            end
        end
    end

    always_comb begin
        stage_flat = '0;
        for (int unsigned w = 0; w < NUM_WORDS; w++)
            stage_flat[32*w +: 32] = stage[w];
    end

    always_comb begin
        rd_word = '0;
        if (rd_idx <= LAST_WORD) begin
            if (KEY_READBACK != 0)
                for (int unsigned w = 0; w < NUM_WORDS; w++)
                    if (rd_idx == 4'(w))
                        rd_word = stage[w];
        end else if (rd_idx == IDX_CTRL) begin
            rd_word = {lock, 23'b0, slot, 4'b0};
        end else if (rd_idx == IDX_STATUS) begin
            rd_word = {8'b0, WORDS_FIELD, commit_cnt, 6'b0, lock, key_valid_q};
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= '0;
        end else begin
            aw_ready <= !aw_ready && S_AXI_AWVALID && S_AXI_WVALID && !b_valid;
            if (wr_en) begin
                b_valid <= 1'b1;
                b_resp  <= wr_err ? 2'b10 : 2'b00;
            end else if (S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            ar_ready <= !ar_ready && S_AXI_ARVALID && !r_valid;
            if (rd_en) begin
                r_valid <= 1'b1;
                r_data  <= rd_word;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++)
                stage[w] <= '0;
            slot <= '0;
            lock <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WORDS; w++)
                if (key_wr && wr_idx == 4'(w))
                    for (int unsigned b = 0; b < 4; b++)
                        if (S_AXI_WSTRB[b])
                            stage[w][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            if (slot_wr)
                slot <= S_AXI_WDATA[7:4];
            if (lock_set)
                lock <= 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            key_q       <= '0;
            key_slot_q  <= '0;
            key_valid_q <= 1'b0;
            commit_cnt  <= '0;
        end else begin
            if (commit_ok) begin
                key_q       <= stage_flat;
                key_slot_q  <= commit_slot;
                key_valid_q <= 1'b1;
            end else if (key_hs) begin
                key_valid_q <= 1'b0;
            end
            if (key_hs)
                commit_cnt <= commit_cnt + 8'd1;
        end
    end
endmodule
